// File: rtl/packet_pkg.sv
// packet_pkg: shared constants and types for the RX packet arbiter.
//   DATA_W / KEEP_W : AXI-Stream data width and byte-enable width per beat
//   CNT_W           : width of each per-port packet counter
//   rx_arb_state_e  : arbiter state (IDLE = arbitrate, BUSY = packet granted)
package packet_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rx_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i        : per-port request vector
//   last_grant_i : index of the previously granted port
//   gnt_idx_o    : first requesting port strictly after last_grant_i (ascending, wrapping)
//   gnt_valid_o  : high when any request is set
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o
);

  // One spare bit so last_grant + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      cand = {1'b0, last_grant_i} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W + 1)'(NUM_PORTS);
      end
      if (!gnt_valid_o && req_i[cand[IDX_W-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rx_pkt_arbiter.sv
// rx_pkt_arbiter: packet-granular round-robin merge of NUM_PORTS AXI-Stream sources.
//   aclk, areset           : clock, synchronous active-high reset
//   s_axis_*               : per-port input streams, port p at slice p
//   m_axis_*               : registered merged output stream
//   port_en                : static per-port arbitration enable (sampled only when idle)
//   grant_port             : port currently or most recently granted
//   busy                   : a packet is currently granted
//   pkt_count              : per-port 32-bit packet counters, present only when the
//                            RX_PKT_ARBITER_CNT_EN macro is defined
module rx_pkt_arbiter
  import packet_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned TUSER_W   = 48
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS*DATA_W-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  input  logic [NUM_PORTS*TUSER_W-1:0]   s_axis_tuser,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic                           m_axis_tvalid,
  output logic [DATA_W-1:0]              m_axis_tdata,
  output logic [KEEP_W-1:0]              m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [TUSER_W-1:0]             m_axis_tuser,
  input  logic                           m_axis_tready,
  input  logic [NUM_PORTS-1:0]           port_en,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_port,
`ifdef RX_PKT_ARBITER_CNT_EN
  output logic [NUM_PORTS*CNT_W-1:0]     pkt_count,
`endif
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  rx_arb_state_e          state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [IdxW-1:0]        last_grant_q, last_grant_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_W-1:0]      m_data_q, m_data_d;
  logic [KEEP_W-1:0]      m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic [TUSER_W-1:0]     m_user_q, m_user_d;

  logic [IdxW-1:0]        rr_idx;
  logic                   rr_valid;
  logic                   out_ready;
  logic                   accept;
  logic                   sel_valid;
  logic [DATA_W-1:0]      sel_data;
  logic [KEEP_W-1:0]      sel_keep;
  logic                   sel_last;
  logic [TUSER_W-1:0]     sel_user;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IdxW)
  ) u_rr_arbiter (
    .req_i        (s_axis_tvalid & port_en),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (rr_idx),
    .gnt_valid_o  (rr_valid)
  );

  // Granted-port mux; the loop keeps every slice index constant.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_user  = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (grant_q == IdxW'(p)) begin
        sel_valid = s_axis_tvalid[p];
        sel_data  = s_axis_tdata[p*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[p*KEEP_W +: KEEP_W];
        sel_last  = s_axis_tlast[p];
        sel_user  = s_axis_tuser[p*TUSER_W +: TUSER_W];
      end
    end
  end

  assign out_ready = !m_valid_q || m_axis_tready;
  assign accept    = (state_q == BUSY) && sel_valid && out_ready;

  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      s_axis_tready[p] = (state_q == BUSY) && (grant_q == IdxW'(p)) && out_ready;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d = BUSY;
          grant_d = rr_idx;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
    endcase
  end

  // Single output register stage: load on accept, drain when the consumer takes it.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_keep_d  = sel_keep;
      m_last_d  = sel_last;
      m_user_d  = sel_user;
    end else if (out_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_PORTS - 1);
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_valid_q    <= m_valid_d;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge aclk) begin
    m_data_q <= m_data_d;
    m_keep_q <= m_keep_d;
    m_last_q <= m_last_d;
    m_user_q <= m_user_d;
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign grant_port    = grant_q;
  assign busy          = (state_q == BUSY);

`ifdef RX_PKT_ARBITER_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];

  always_ff @(posedge aclk) begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (areset) begin
        cnt_q[p] <= '0;
      end else if (accept && sel_last && (grant_q == IdxW'(p))) begin
        cnt_q[p] <= cnt_q[p] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      pkt_count[p*CNT_W +: CNT_W] = cnt_q[p];
    end
  end
`endif

endmodule

// File: doc/rx_pkt_arbiter.md
RX_PKT_ARBITER -- requirements
Module: rx_pkt_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of AXI-Stream sources; legal range 2..4.
REQ-002 Parameter TUSER_W, default 48, tuser width per port.
REQ-003 aclk  input  1  sole clock; all logic on posedge aclk.
REQ-004 areset  input  1  reset; synchronous, active-high.
REQ-005 s_axis_tvalid  input  NUM_PORTS  per-port beat valid.
REQ-006 s_axis_tdata  input  NUM_PORTS*512  per-port data; port p occupies bits [p*512 +: 512].
REQ-007 s_axis_tkeep  input  NUM_PORTS*64  per-port byte enables; port p at [p*64 +: 64].
REQ-008 s_axis_tlast  input  NUM_PORTS  per-port end of packet.
REQ-009 s_axis_tuser  input  NUM_PORTS*TUSER_W  per-port sideband.
REQ-010 s_axis_tready  output  NUM_PORTS  per-port ready.
REQ-011 m_axis_tvalid/tdata/tkeep/tlast/tuser  output  1/512/64/1/TUSER_W  merged stream to filter_rx_pipeline.
REQ-012 m_axis_tready  input  1  downstream ready.
REQ-013 port_en  input  NUM_PORTS  per-port arbitration enable (static config).
REQ-014 grant_port  output  $clog2(NUM_PORTS)  index of the port currently or last granted.
REQ-015 busy  output  1  high while a packet is granted (state BUSY).

Function
REQ-016 The block SHALL implement two states: IDLE and BUSY.
REQ-017 In IDLE, req = s_axis_tvalid & port_en; if req != 0 the next state SHALL be BUSY with grant = first set req bit after last_grant in ascending round-robin order (wrapping NUM_PORTS-1 -> 0).
REQ-018 In IDLE, all s_axis_tready bits SHALL be 0.
REQ-019 out_ready = !m_axis_tvalid || m_axis_tready; in BUSY, s_axis_tready[grant] = out_ready and all other bits SHALL be 0.
REQ-020 A beat SHALL be accepted when s_axis_tvalid[grant] && s_axis_tready[grant]; its tdata/tkeep/tlast/tuser SHALL be loaded into the output register unchanged and m_axis_tvalid SHALL be set.
REQ-021 When out_ready and no beat is accepted, m_axis_tvalid SHALL clear; when !out_ready the output register SHALL hold.
REQ-022 An accepted beat with tlast=1 SHALL return state to IDLE and set last_grant <= grant.
REQ-023 Latency: first beat on m_axis SHALL appear 2 cycles after s_axis_tvalid rises in IDLE with m_axis_tready=1; exactly one idle arbitration cycle separates packets.
REQ-024 Grant SHALL be held until tlast regardless of port_en or other requests; port_en is only sampled in IDLE.
REQ-025 Single-beat packets (tvalid and tlast in the same beat) SHALL be handled without extra cycles.
REQ-026 Sustained throughput within a packet SHALL be one beat per cycle while m_axis_tready=1.
REQ-027 A port with port_en=0 SHALL never be granted; its tready stays 0.

Reset
REQ-028 On areset: state=IDLE, m_axis_tvalid=0, s_axis_tready=0, busy=0, grant_port=0, last_grant=NUM_PORTS-1 (port 0 wins first), counters=0.
REQ-029 Reset mid-packet SHALL discard the in-flight packet; no partial beat is emitted after reset release.
REQ-030 m_axis_tdata/tkeep/tlast/tuser are don't-care while m_axis_tvalid=0.

Configuration
REQ-031 Macro RX_PKT_ARBITER_CNT_EN defined: output pkt_count (NUM_PORTS*32) SHALL exist, port p's 32-bit counter incrementing on each accepted tlast beat from p, wrapping 0xFFFFFFFF -> 0.
REQ-032 Macro undefined: pkt_count port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 State enum (rx_arb_state_e: IDLE, BUSY) and the data-width constants SHALL live in packet_pkg.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, last_grant; outputs gnt_idx, gnt_valid).

Verification
REQ-035 Port 0 only, 3-beat packet, tready=1 -> beats on m_axis at cycles 2,3,4, tlast on beat 3, grant_port=0.
REQ-036 Both ports continuously valid, 1-beat packets -> grants alternate 0,1,0,1; each packet separated by one idle cycle.
REQ-037 Port 1 mid-packet, port 0 asserts valid -> port 0 tready stays 0 until port 1 tlast accepted; port 0 is granted next.
REQ-038 m_axis_tready=0 for 4 cycles mid-packet -> output held stable, s_axis_tready[grant]=0, no beat lost or duplicated.
REQ-039 port_en=2'b10, both valid -> only port 1 granted; port 0 tready never 1.
REQ-040 areset asserted during beat 2 of 4 -> next cycle m_axis_tvalid=0, state IDLE; with RX_PKT_ARBITER_CNT_EN, counter 0xFFFFFFFF + one packet -> 0.
